// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: widths, reset/flush constants and
// the fetch controller state encoding.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select (hold / PC+4 / redirect target) with the
// alignment check on redirect targets.
module fetch_pc_next #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            fetch_en,
  input  logic            load,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  always_comb begin
    pc_plus4   = pc + XLEN'(4);
    misaligned = fetch_en & redirect_valid & (redirect_target[1:0] != 2'b00);
    pc_next    = pc;
    if (fetch_en) begin
      // A misaligned target freezes the PC; the controller halts instead.
      if (redirect_valid) begin
        if (!misaligned) begin
          pc_next = redirect_target;
        end
      end else if (load) begin
        pc_next = pc_plus4;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and IF/ID stage: fetches one word per cycle from instruction
// memory and hands it to decode over a valid/ready handshake.
module fetch_unit #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr,
  output logic            fetch_fault,
  output logic [31:0]     fetch_count
);

  import riscv_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            id_valid_reg;
  logic [XLEN-1:0] id_pc_reg;
  logic [XLEN-1:0] id_pc_plus4_reg;
  logic [31:0]     id_instr_reg;
  logic            fetch_fault_reg;
  logic [31:0]     fetch_count_reg;

  logic fetch_en;
  logic load;
  logic handshake;
  logic misaligned;

  assign fetch_en  = (state_reg == S_FETCH);
  assign load      = fetch_en & (~id_valid_reg | id_ready) & ~redirect_valid;
  assign handshake = id_valid_reg & id_ready;

  fetch_pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .pc              (pc_reg),
    .fetch_en        (fetch_en),
    .load            (load),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_next         (pc_next),
    .pc_plus4        (pc_plus4),
    .misaligned      (misaligned)
  );

  // Boot spends one cycle idle so the memory can leave its own reset output.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_BOOT:  state_next = S_FETCH;
      S_FETCH: if (misaligned) state_next = S_HALT;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg          <= RESET_PC;
      id_valid_reg    <= 1'b0;
      id_pc_reg       <= '0;
      id_pc_plus4_reg <= '0;
      id_instr_reg    <= NOP_INSTR;
      fetch_fault_reg <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (handshake) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (misaligned) begin
        fetch_fault_reg <= 1'b1;
      end
      // Redirect beats both stall and load, flushing regardless of id_ready.
      if (fetch_en && redirect_valid) begin
        id_valid_reg <= 1'b0;
        if (!misaligned) begin
          id_instr_reg <= NOP_INSTR;
        end
      end else if (load) begin
        id_valid_reg    <= 1'b1;
        id_pc_reg       <= pc_reg;
        id_pc_plus4_reg <= pc_plus4;
        id_instr_reg    <= imem_instr;
      end else if (id_ready) begin
        id_valid_reg <= 1'b0;
      end
    end
  end

  assign imem_pc     = pc_reg;
  assign id_valid    = id_valid_reg;
  assign id_pc       = id_pc_reg;
  assign id_pc_plus4 = id_pc_plus4_reg;
  assign id_instr    = id_instr_reg;
  assign fetch_fault = fetch_fault_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];
  assign imem_instr = mem[imem_pc[7:2]];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_pc         (imem_pc),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_instr        (id_instr),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: next address to fetch, the word sitting in IF/ID, delivered count.
  logic [31:0] m_addr, m_pc, m_pc4, m_instr, m_count;
  bit          m_valid, m_fault, m_boot, m_halt;

  task automatic model_reset();
    m_addr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h13; m_count = 32'h0;
    m_valid = 0; m_fault = 0; m_boot = 1; m_halt = 0;
  endtask

  // Apply inputs, advance the model by one cycle, then clock the DUT.
  task automatic tick(input bit rdy, input bit rv, input logic [31:0] tgt);
    bit hs;
    id_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_halt) begin
      hs = m_valid && rdy;
      if (hs) m_count = m_count + 1;
      if (rv) begin
        m_valid = 0;
        if (tgt[1:0] != 2'b00) begin
          m_fault = 1; m_halt = 1;
        end else begin
          m_addr = tgt; m_instr = 32'h13;
        end
      end else if (!m_valid || hs) begin
        m_pc = m_addr; m_pc4 = m_addr + 32'd4; m_instr = mem[m_addr[7:2]];
        m_valid = 1; m_addr = m_addr + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    model_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %0b exp 0", id_valid); end
    checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL rst_imem_pc got %h exp 00000000", imem_pc); end
    checks++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h/%h exp 0/0", id_pc, id_pc_plus4); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL rst_id_instr got %h exp 00000013", id_instr); end
    checks++; if (fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL rst_fault_count got %0b/%0d exp 0/0", fetch_fault, fetch_count); end
    @(negedge clk); reset_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_stream();
    tick(1, 0, 0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL boot_no_capture got id_valid=%0b exp 0", id_valid); end
    tick(1, 0, 0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h00300093) begin
      errors++; $display("FAIL stream_first got v=%0b pc=%h instr=%h exp v=1 pc=00000000 instr=00300093", id_valid, id_pc, id_instr); end
    tick(1, 0, 0);
    checks++; if (id_pc !== 32'h4 || id_instr !== 32'h00500113 || id_pc_plus4 !== 32'h8) begin
      errors++; $display("FAIL stream_second got pc=%h instr=%h pc4=%h exp 00000004 00500113 00000008", id_pc, id_instr, id_pc_plus4); end
    checks++; if (fetch_count !== m_count) begin errors++; $display("FAIL stream_count got %0d exp %0d", fetch_count, m_count); end
    $display("stream: pc=%h instr=%h count=%0d", id_pc, id_instr, fetch_count);
  endtask

  task automatic test_backpressure();
    logic [31:0] cnt_hold;
    tick(1, 0, 0);
    checks++; if (id_pc !== 32'h8 || imem_pc !== 32'hC) begin errors++; $display("FAIL bp_setup got pc=%h imem=%h exp 00000008 0000000c", id_pc, imem_pc); end
    cnt_hold = m_count;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== mem[2] || imem_pc !== 32'hC) begin
        errors++; $display("FAIL bp_hold%0d got v=%0b pc=%h instr=%h imem=%h exp 1 00000008 %h 0000000c", i, id_valid, id_pc, id_instr, imem_pc, mem[2]); end
      checks++; if (fetch_count !== cnt_hold) begin errors++; $display("FAIL bp_count%0d got %0d exp %0d", i, fetch_count, cnt_hold); end
    end
    tick(1, 0, 0);
    checks++; if (id_pc !== 32'hC || id_instr !== mem[3]) begin errors++; $display("FAIL bp_release got pc=%h instr=%h exp 0000000c %h", id_pc, id_instr, mem[3]); end
    $display("backpressure: released pc=%h count=%0d", id_pc, fetch_count);
  endtask

  task automatic test_redirect_flush();
    tick(0, 0, 0);
    tick(0, 1, 32'h40);
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || imem_pc !== 32'h40) begin
      errors++; $display("FAIL flush got v=%0b instr=%h imem=%h exp 0 00000013 00000040", id_valid, id_instr, imem_pc); end
    tick(1, 0, 0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem[16]) begin
      errors++; $display("FAIL flush_target got v=%0b pc=%h instr=%h exp 1 00000040 %h", id_valid, id_pc, id_instr, mem[16]); end
    $display("redirect: pc=%h instr=%h", id_pc, id_instr);
  endtask

  task automatic test_wrap();
    tick(1, 1, 32'hFFFF_FFFC);
    checks++; if (imem_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_imem got %h exp fffffffc", imem_pc); end
    tick(1, 0, 0);
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0 || id_instr !== mem[63]) begin
      errors++; $display("FAIL wrap_id got pc=%h pc4=%h instr=%h exp fffffffc 00000000 %h", id_pc, id_pc_plus4, id_instr, mem[63]); end
    tick(1, 0, 0);
    checks++; if (id_pc !== 32'h0 || id_instr !== mem[0]) begin errors++; $display("FAIL wrap_next got pc=%h instr=%h exp 00000000 %h", id_pc, id_instr, mem[0]); end
    $display("wrap: pc=%h pc4=%h", id_pc, id_pc_plus4);
  endtask

  task automatic test_misaligned_halt();
    logic [31:0] pc_hold, cnt_hold;
    tick(1, 0, 0);
    pc_hold = imem_pc;
    tick(1, 1, 32'h42);
    cnt_hold = m_count;
    checks++; if (fetch_fault !== 1'b1 || id_valid !== 1'b0 || imem_pc !== pc_hold) begin
      errors++; $display("FAIL misalign got fault=%0b v=%0b imem=%h exp 1 0 %h", fetch_fault, id_valid, imem_pc, pc_hold); end
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 32'h80);
      checks++; if (id_valid !== 1'b0 || imem_pc !== pc_hold || fetch_count !== cnt_hold || fetch_fault !== 1'b1) begin
        errors++; $display("FAIL halt%0d got v=%0b imem=%h cnt=%0d fault=%0b exp 0 %h %0d 1", i, id_valid, imem_pc, fetch_count, fetch_fault, pc_hold, cnt_hold); end
    end
    reset_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_pc !== 32'h0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== 32'h13 || fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
      errors++; $display("FAIL halt_reset got v=%0b imem=%h pc=%h pc4=%h instr=%h fault=%0b cnt=%0d exp reset values", id_valid, imem_pc, id_pc, id_pc_plus4, id_instr, fetch_fault, fetch_count); end
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    $display("halt: cleared by reset");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_pc !== 32'h0 || fetch_count !== 32'h0 || id_instr !== 32'h13 || id_pc !== 32'h0) begin
      errors++; $display("FAIL async_reset got v=%0b imem=%h cnt=%0d instr=%h pc=%h exp reset values", id_valid, imem_pc, fetch_count, id_instr, id_pc); end
    #1 reset_n = 1'b1;
    model_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mem[0]) begin
      errors++; $display("FAIL async_restart got v=%0b pc=%h instr=%h exp 1 00000000 %h", id_valid, id_pc, id_instr, mem[0]); end
    $display("async reset: restarted pc=%h", id_pc);
  endtask

  task automatic test_random();
    bit          rdy, rv;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom % 4) != 0;
      rv  = ($urandom % 12) == 0;
      tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + (($urandom % 4) * 4) : ($urandom & 32'h0000_00FC);
      if (id_valid && rdy && !$isunknown(id_pc)) $display("xfer pc=%h instr=%h", id_pc, id_instr);
      tick(rdy, rv, tgt);
      checks++; if (id_valid !== m_valid || imem_pc !== m_addr) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d got v=%0b imem=%h exp v=%0b imem=%h", i, id_valid, imem_pc, m_valid, m_addr); end
      checks++; if (id_pc !== m_pc || id_pc_plus4 !== m_pc4 || id_instr !== m_instr) begin
        errors++; $display("FAIL rnd_data cyc %0d got %h/%h/%h exp %h/%h/%h", i, id_pc, id_pc_plus4, id_instr, m_pc, m_pc4, m_instr); end
      checks++; if (fetch_count !== m_count || fetch_fault !== m_fault) begin
        errors++; $display("FAIL rnd_count cyc %0d got %0d/%0b exp %0d/%0b", i, fetch_count, fetch_fault, m_count, m_fault); end
    end
  endtask

  initial begin
    id_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0030_0093;
    mem[1] = 32'h0050_0113;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_wrap();
    test_misaligned_halt();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
